tmc4671_spi_slave: RTL and testbench
====================================

Name: tmc4671_spi_slave

Overview:
- SPI responder (target side) of the TMC4671 datagram link, used as the device model behind the SPI master's SCK/MOSI/MISO/nSCS pins in simulation and as a register-access bridge in FPGA loopback builds.
- Oversamples the SPI pins on the system clock in mode 3 (CPOL=1, CPHA=1), MSB first, 40-bit frames: bit39 = write flag, bits 38:32 = address, bits 31:0 = data.
- Decodes each frame into a write strobe or a read request.
- Shifts a status byte and the read data back on MISO.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCK, MOSI and nSCS (allowed range 2..3).
- RD_LATENCY, 2, clk cycles from rd_req to rd_data valid (allowed range 1..4).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- SCK  input  1  SPI clock from master; idles high.
- MOSI  input  1  master-to-slave data.
- MISO  output  1  slave-to-master data.
- miso_oe  output  1  MISO drive enable; high while a frame is active.
- nSCS  input  1  active-low chip select.
- status  input  8  status byte returned in MISO bits 39:32.
- rd_req  output  1  one-cycle read request.
- rd_addr  output  7  read address; held from rd_req until frame end.
- rd_data  input  32  read data; sampled RD_LATENCY cycles after rd_req.
- wr_valid  output  1  one-cycle write strobe.
- wr_addr  output  7  write address, valid with wr_valid.
- wr_data  output  32  write data, valid with wr_valid.
- frame_err  output  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset values: MISO=0, miso_oe=0, rd_req=0, rd_addr=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0. State = WAIT_IDLE.
- Input path: SCK, MOSI and nSCS pass through SYNC_STAGES flops, then one edge-detect register. Pin-to-detected-edge delay = SYNC_STAGES+1 clk.
- Timing constraints on the master:
  - SCK low phase >= SYNC_STAGES+3 clk.
  - SCK high phase >= SYNC_STAGES+RD_LATENCY+3 clk.
  - nSCS setup and hold around SCK edges >= 1 SCK half period.
- States:
  - WAIT_IDLE: wait for synced nSCS=1, then go to IDLE. Guarantees that a reset mid-frame never decodes a partial frame.
  - IDLE: on detected nSCS fall, capture status into tx_shift[39:32], set tx_shift[31:0]=0, clear the bit counter, set miso_oe=1, MISO=0, go to ADDR.
  - ADDR: on each detected SCK fall, MISO <= tx_shift[39] and tx_shift shifts left. On each detected SCK rise, rx_shift <= {rx_shift[38:0], MOSI_sync} and the counter increments. On the 8th rise, pulse rd_req with rd_addr = rx_shift bits 6:0 (the address), go to DATA.
  - DATA: same shifting. Exactly RD_LATENCY cycles after rd_req, load tx_shift[39:8] with rd_data, so falling edge 9 presents rd_data[31]. The read is issued for both write and read frames, so a write returns the register's prior value. On the 40th rise, go to DONE.
  - DONE: SCK edges are ignored. On nSCS rise: if rx bit39=1, pulse wr_valid with wr_addr=rx[38:32], wr_data=rx[31:0]. A read frame produces no strobe. Go to IDLE.
  - ERR: entered from ADDR or DATA when nSCS rises with fewer than 40 rises (frame_err pulses, no wr_valid), or from DONE on a 41st rise (frame_err pulses; wait for nSCS rise with no strobe). Then go to IDLE.
- Strobe timing: wr_valid and frame_err pulse in the same cycle the nSCS rise is detected (or the 41st rise, for frame_err). On every nSCS rise, miso_oe drops and MISO=0 on the next clk.
- Same-cycle nSCS rise and SCK rise: nSCS wins; the SCK edge is ignored.
- Back-to-back frames: a new nSCS fall is accepted the cycle after returning to IDLE.
- Bit counter is 6 bits and saturates at 41; it does not wrap.
- Asynchronous reset mid-frame: all outputs return to reset values immediately; the in-flight frame is discarded.

Test Plan:
- Write frame MOSI=0x81_DEADBEEF, SCK period 20 clk → exactly one wr_valid, wr_addr=0x01, wr_data=0xDEADBEEF; rd_req once with rd_addr=0x01; no frame_err.
- Read frame MOSI=0x15_00000000, status=0xA5, rd_data=0x12345678 → MISO bits captured on SCK rises = 0xA5_12345678; rd_addr=0x15; no wr_valid.
- nSCS raised after 20 bits of a write frame → frame_err single pulse; wr_valid stays 0; next valid frame decodes correctly.
- 41 SCK cycles in one frame → frame_err pulse at the 41st rise; no wr_valid at nSCS rise.
- reset low during bit 12 of a write frame, nSCS held low after release → outputs at reset values; remaining bits ignored; first frame after nSCS rises decodes normally.
- Two write frames with 1 SCK period of nSCS-high gap (addr 0x02 data 0x1, then addr 0x03 data 0x2) → two wr_valid pulses with correct pairs, in order.

Source files
------------

// File: rtl/tmc4671_spi_slave.sv
// TMC4671 datagram SPI responder (mode 3, MSB first, 40-bit frames).
// Oversamples SCK/MOSI/nSCS on clk, decodes write strobes and read requests,
// and returns a status byte followed by read data on MISO.
module tmc4671_spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        miso_oe,
    input  logic        nSCS,
    input  logic [7:0]  status,
    output logic        rd_req,
    output logic [6:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        ADDR,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] nscs_sync;
    logic                   sck_d;
    logic                   nscs_d;
    logic [39:0]            tx_shift;
    logic [39:0]            rx_shift;
    logic [5:0]             bit_cnt;
    logic [2:0]             lat_cnt;

    logic sck_s, mosi_s, nscs_s;
    logic sck_rise, sck_fall, nscs_rise, nscs_fall;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign nscs_s    = nscs_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign nscs_rise = nscs_s & ~nscs_d;
    assign nscs_fall = ~nscs_s & nscs_d;

    // Pin synchronizers plus edge-detect registers. nSCS resets to the
    // asserted level so a chip select still low after reset is not seen as
    // a fresh frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '1;
            mosi_sync <= '0;
            nscs_sync <= '0;
            sck_d     <= 1'b1;
            nscs_d    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            nscs_sync <= {nscs_sync[SYNC_STAGES-2:0], nSCS};
            sck_d     <= sck_s;
            nscs_d    <= nscs_s;
        end
    end

    // Frame state machine with registered outputs and shift registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_IDLE;
            MISO      <= 1'b0;
            miso_oe   <= 1'b0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
        end else begin
            rd_req    <= 1'b0;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (lat_cnt != 3'd0)
                lat_cnt <= lat_cnt - 3'd1;

            case (state)
                WAIT_IDLE: begin
                    miso_oe <= 1'b0;
                    MISO    <= 1'b0;
                    if (nscs_s)
                        state <= IDLE;
                end
                IDLE: begin
                    if (nscs_fall) begin
                        tx_shift <= {status, 32'h0};
                        bit_cnt  <= '0;
                        lat_cnt  <= '0;
                        miso_oe  <= 1'b1;
                        MISO     <= 1'b0;
                        state    <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    // nSCS rise takes priority over a coincident SCK rise.
                    if (nscs_rise) begin
                        frame_err <= 1'b1;
                        miso_oe   <= 1'b0;
                        MISO      <= 1'b0;
                        lat_cnt   <= '0;
                        state     <= ERR;
                    end else begin
                        if (sck_fall) begin
                            MISO     <= tx_shift[39];
                            tx_shift <= {tx_shift[38:0], 1'b0};
                        end
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[38:0], mosi_s};
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (state == ADDR && bit_cnt == 6'd7) begin
                                rd_req  <= 1'b1;
                                rd_addr <= {rx_shift[5:0], mosi_s};
                                lat_cnt <= 3'(RD_LATENCY);
                                state   <= DATA;
                            end else if (state == DATA && bit_cnt == 6'd39) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (nscs_rise) begin
                        if (rx_shift[39]) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= rx_shift[38:32];
                            wr_data  <= rx_shift[31:0];
                        end
                        miso_oe <= 1'b0;
                        MISO    <= 1'b0;
                        state   <= IDLE;
                    end else if (sck_rise) begin
                        bit_cnt   <= 6'd41;
                        frame_err <= 1'b1;
                        state     <= ERR;
                    end
                end
                ERR: begin
                    if (nscs_s) begin
                        miso_oe <= 1'b0;
                        MISO    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase

            // Read data lands in the payload bits once the latency expires,
            // after the status byte has been shifted out.
            if (state == DATA && lat_cnt == 3'd1)
                tx_shift[39:8] <= rd_data;
        end
    end

endmodule

// File: tb/tb_tmc4671_spi_slave.sv
// Self-checking bench for tmc4671_spi_slave: table-driven frames plus
// hand-written sequences for overrun, mid-frame reset and back-to-back frames.
module tb_tmc4671_spi_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        SCK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        miso_oe;
    logic        nSCS = 1'b1;
    logic [7:0]  status = 8'h00;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data = 32'h0;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;

    tmc4671_spi_slave #(.SYNC_STAGES(2), .RD_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .miso_oe(miso_oe), .nSCS(nSCS), .status(status), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ferr_cnt = 0;
    logic [6:0] last_raddr = '0;
    logic [38:0] wr_q[$];

    // Pulse monitor, sampling on the falling clk edge.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            wr_q.push_back({wr_addr, wr_data});
        end
        if (rd_req) begin
            rd_cnt++;
            last_raddr = rd_addr;
        end
        if (frame_err)
            ferr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_bits(input logic [39:0] data, input int nbits, output logic [39:0] cap);
        cap = '0;
        nSCS = 1'b0;
        wait_clk(10);
        for (int i = 0; i < nbits; i++) begin
            SCK = 1'b0;
            MOSI = (i < 40) ? data[39 - i] : 1'b0;
            wait_clk(10);
            cap = {cap[38:0], MISO};
            SCK = 1'b1;
            wait_clk(10);
        end
    endtask

    task automatic frame_end(input int gap);
        wait_clk(10);
        nSCS = 1'b1;
        wait_clk(gap);
    endtask

    task automatic pop_wr(input string name, input logic [6:0] ea, input logic [31:0] ed);
        logic [38:0] e;
        if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            chk({name, "_addr"}, 64'(e[38:32]), 64'(ea));
            chk({name, "_data"}, 64'(e[31:0]), 64'(ed));
        end else begin
            chk({name, "_present"}, 64'd0, 64'd1);
        end
    endtask

    typedef struct {
        string       name;
        logic [39:0] mosi;
        logic [7:0]  stat;
        logic [31:0] rdd;
        int          nbits;
        logic        exp_wr;
        logic [6:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [6:0]  exp_raddr;
        logic [39:0] exp_miso;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [39:0] cap;
        int w0, r0, f0;

        vecs[0] = '{"wr81", 40'h81_DEADBEEF, 8'h00, 32'hCAFEF00D, 40, 1'b1, 7'h01, 32'hDEADBEEF, 7'h01, 40'h00_CAFEF00D, 0};
        vecs[1] = '{"rd15", 40'h15_00000000, 8'hA5, 32'h12345678, 40, 1'b0, 7'h00, 32'h0, 7'h15, 40'hA5_12345678, 0};
        vecs[2] = '{"wrFF", 40'hFF_00000001, 8'h3C, 32'hFFFFFFFF, 40, 1'b1, 7'h7F, 32'h00000001, 7'h7F, 40'h3C_FFFFFFFF, 0};
        vecs[3] = '{"rd00", 40'h00_FFFFFFFF, 8'h00, 32'h00000000, 40, 1'b0, 7'h00, 32'h0, 7'h00, 40'h00_00000000, 0};
        vecs[4] = '{"short20", 40'h81_DEADBEEF, 8'h5A, 32'h0, 20, 1'b0, 7'h00, 32'h0, 7'h01, 40'h0, 1};

        // Reset state
        wait_clk(3);
        chk("rst_MISO", 64'(MISO), 64'd0);
        chk("rst_miso_oe", 64'(miso_oe), 64'd0);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        reset = 1'b1;
        wait_clk(10);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt;
            status = vecs[v].stat;
            rd_data = vecs[v].rdd;
            frame_bits(vecs[v].mosi, vecs[v].nbits, cap);
            chk({vecs[v].name, "_oe_active"}, 64'(miso_oe), 64'd1);
            frame_end(20);
            chk({vecs[v].name, "_wr_cnt"}, 64'(wr_cnt - w0), 64'(int'(vecs[v].exp_wr)));
            if (vecs[v].exp_wr)
                pop_wr(vecs[v].name, vecs[v].exp_waddr, vecs[v].exp_wdata);
            chk({vecs[v].name, "_rd_cnt"}, 64'(rd_cnt - r0), 64'd1);
            chk({vecs[v].name, "_rd_addr"}, 64'(last_raddr), 64'(vecs[v].exp_raddr));
            chk({vecs[v].name, "_ferr_cnt"}, 64'(ferr_cnt - f0), 64'(vecs[v].exp_ferr));
            if (vecs[v].nbits == 40)
                chk({vecs[v].name, "_miso"}, 64'(cap), 64'(vecs[v].exp_miso));
            chk({vecs[v].name, "_oe_off"}, 64'(miso_oe), 64'd0);
            chk({vecs[v].name, "_miso_idle"}, 64'(MISO), 64'd0);
        end

        // 41 SCK cycles: frame_err at the 41st rise, no strobe at nSCS rise
        w0 = wr_cnt; f0 = ferr_cnt;
        status = 8'h00; rd_data = 32'h0;
        frame_bits(40'h84_00000055, 41, cap);
        chk("over41_ferr_before_cs", 64'(ferr_cnt - f0), 64'd1);
        frame_end(20);
        chk("over41_ferr_total", 64'(ferr_cnt - f0), 64'd1);
        chk("over41_wr_cnt", 64'(wr_cnt - w0), 64'd0);

        // Asynchronous reset during bit 12 of a write frame
        nSCS = 1'b0;
        wait_clk(10);
        for (int i = 0; i < 40; i++) begin
            SCK = 1'b0;
            MOSI = (i % 3 == 0);
            wait_clk(10);
            if (i == 11) begin
                reset = 1'b0;
                #1;
                chk("mid_rst_miso_oe", 64'(miso_oe), 64'd0);
                chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
                chk("mid_rst_MISO", 64'(MISO), 64'd0);
                chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
                wait_clk(3);
                reset = 1'b1;
                w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt;
            end
            SCK = 1'b1;
            wait_clk(10);
        end
        chk("mid_rst_oe_held_off", 64'(miso_oe), 64'd0);
        frame_end(20);
        chk("mid_rst_wr_cnt", 64'(wr_cnt - w0), 64'd0);
        chk("mid_rst_rd_cnt", 64'(rd_cnt - r0), 64'd0);
        chk("mid_rst_ferr_cnt", 64'(ferr_cnt - f0), 64'd0);
        w0 = wr_cnt;
        frame_bits(40'h83_0000ABCD, 40, cap);
        frame_end(20);
        chk("post_rst_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        pop_wr("post_rst", 7'h03, 32'h0000ABCD);

        // Back-to-back write frames with one SCK period of nSCS high
        w0 = wr_cnt; f0 = ferr_cnt;
        frame_bits(40'h82_00000001, 40, cap);
        frame_end(20);
        frame_bits(40'h83_00000002, 40, cap);
        frame_end(20);
        chk("b2b_wr_cnt", 64'(wr_cnt - w0), 64'd2);
        chk("b2b_ferr_cnt", 64'(ferr_cnt - f0), 64'd0);
        pop_wr("b2b_first", 7'h02, 32'h00000001);
        pop_wr("b2b_second", 7'h03, 32'h00000002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
